// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ariane_pkg
// Description : Minimal stand-in for the scoreboard types the issue-entry
//               FIFO carries. Only the fields the FIFO and its neighbours
//               need are present; the FIFO treats the entry as opaque apart
//               from the functional-unit field.
// Revision    : 1.0 - initial release
// ============================================================================
package ariane_pkg;

   typedef enum logic [3:0] {
      NONE,
      LOAD,
      STORE,
      ALU,
      CTRL_FLOW,
      MULT,
      CSR,
      FPU,
      FPU_VEC,
      CVXIF
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [2:0]  trans_id;
      fu_t         fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;
      logic        use_imm;
      logic        use_zimm;
      logic        use_pc;
      exception_t  ex;
      logic        is_compressed;
   } scoreboard_entry_t;

endpackage
`default_nettype wire

// File: rtl/issue_entry_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface   : issue_entry_fifo_if
// Description : Decode-side push port, issue-side pop port and the occupancy
//               / lookahead status of the issue-entry FIFO. The FIFO uses
//               the slave modport; the surrounding pipeline uses master.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_entry_fifo_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   // synchronous flush of all held entries
   logic                          flush_i;
   // decode-side push
   ariane_pkg::scoreboard_entry_t decoded_entry_i;
   logic                          decoded_entry_valid_i;
   logic                          is_ctrl_flow_i;
   logic                          decoded_entry_ack_o;
   // issue-side pop
   ariane_pkg::scoreboard_entry_t issue_entry_o;
   logic                          issue_entry_valid_o;
   logic                          is_ctrl_flow_o;
   logic                          issue_instr_ack_i;
   // lookahead and occupancy
   logic                          next_valid_o;
   logic                          next_is_mem_o;
   logic [PTR_W:0]                count_o;
   logic [PTR_W:0]                mem_count_o;

   modport slave (
      input  flush_i,
      input  decoded_entry_i,
      input  decoded_entry_valid_i,
      input  is_ctrl_flow_i,
      output decoded_entry_ack_o,
      output issue_entry_o,
      output issue_entry_valid_o,
      output is_ctrl_flow_o,
      input  issue_instr_ack_i,
      output next_valid_o,
      output next_is_mem_o,
      output count_o,
      output mem_count_o
   );

   modport master (
      output flush_i,
      output decoded_entry_i,
      output decoded_entry_valid_i,
      output is_ctrl_flow_i,
      input  decoded_entry_ack_o,
      input  issue_entry_o,
      input  issue_entry_valid_o,
      input  is_ctrl_flow_o,
      output issue_instr_ack_i,
      input  next_valid_o,
      input  next_is_mem_o,
      input  count_o,
      input  mem_count_o
   );

endinterface
`default_nettype wire

// File: rtl/issue_entry_fifo.sv
`default_nettype none
// ============================================================================
// Module      : issue_entry_fifo
// Description : Circular buffer of decoded scoreboard entries between the
//               ID stage and the issue-side reorder stage. Presents the
//               oldest entry, a one-entry lookahead and a count of held
//               LOAD/STORE entries. Push is not bypassed to the output, and
//               a full FIFO does not accept even when popping that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_entry_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   issue_entry_fifo_if.slave  bus
);

   localparam int unsigned    PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] TWO_CNT  = (PTR_W + 1)'(2);

   function automatic logic is_mem(input ariane_pkg::fu_t fu);
      return (fu == ariane_pkg::LOAD) || (fu == ariane_pkg::STORE);
   endfunction

   ariane_pkg::scoreboard_entry_t mem_q  [DEPTH];
   ariane_pkg::scoreboard_entry_t mem_d  [DEPTH];
   logic                          ctrl_q [DEPTH];
   logic                          ctrl_d [DEPTH];

   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_nxt;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic [PTR_W:0]   mcnt_q, mcnt_d;

   logic push;
   logic pop;
   logic push_mem;
   logic pop_mem;

   // Handshake qualification: flush and full block acceptance, and the
   // full check uses the registered count so a pop never enables a push
   // in the same cycle.
   always_comb begin
      push     = bus.decoded_entry_valid_i & (cnt_q != FULL_CNT) & ~bus.flush_i & ~rst_i;
      pop      = bus.issue_instr_ack_i & (cnt_q != '0) & ~bus.flush_i;
      push_mem = push & is_mem(bus.decoded_entry_i.fu);
      pop_mem  = pop & is_mem(mem_q[rd_q].fu);
      rd_nxt   = rd_q + PTR_W'(1);
   end

   // Next-state for pointers and counters; flush returns everything to empty.
   always_comb begin
      rd_d   = rd_q;
      wr_d   = wr_q;
      cnt_d  = cnt_q;
      mcnt_d = mcnt_q;
      if (bus.flush_i) begin
         rd_d   = '0;
         wr_d   = '0;
         cnt_d  = '0;
         mcnt_d = '0;
      end else begin
         if (push) wr_d = wr_q + PTR_W'(1);
         if (pop)  rd_d = rd_nxt;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
         endcase
         case ({push_mem, pop_mem})
            2'b10:   mcnt_d = mcnt_q + (PTR_W + 1)'(1);
            2'b01:   mcnt_d = mcnt_q - (PTR_W + 1)'(1);
            default: mcnt_d = mcnt_q;
         endcase
      end
   end

   // Next-state for the storage array: only the write slot changes on push.
   always_comb begin
      mem_d  = mem_q;
      ctrl_d = ctrl_q;
      if (push) begin
         mem_d[wr_q]  = bus.decoded_entry_i;
         ctrl_d[wr_q] = bus.is_ctrl_flow_i;
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         mcnt_q <= '0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   // Payload storage is never reset; validity comes from the count.
   always_ff @(posedge clk_i) begin
      mem_q  <= mem_d;
      ctrl_q <= ctrl_d;
   end

   assign bus.decoded_entry_ack_o = push;
   assign bus.issue_entry_o       = mem_q[rd_q];
   assign bus.is_ctrl_flow_o      = ctrl_q[rd_q];
   assign bus.issue_entry_valid_o = (cnt_q != '0);
   assign bus.next_valid_o        = (cnt_q >= TWO_CNT);
   assign bus.next_is_mem_o       = (cnt_q >= TWO_CNT) & is_mem(mem_q[rd_nxt].fu);
   assign bus.count_o             = cnt_q;
   assign bus.mem_count_o         = mcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_entry_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_entry_fifo
// Description : Self-checking bench for issue_entry_fifo: a table of
//               per-cycle vectors followed by hand-written sequences for
//               steady-state push/pop, flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_entry_fifo;
   import ariane_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk_i;
   logic rst_i;

   int n_pass  = 0;
   int n_total = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   issue_entry_fifo_if #(.DEPTH(DEPTH)) bus ();

   issue_entry_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   typedef struct {
      logic        v;
      fu_t         fu;
      logic [63:0] pc;
      logic        ex;
      logic        ack_in;
      logic        flush;
      logic        e_ack;
      int          e_cnt;
      int          e_mcnt;
      logic        e_val;
      logic [63:0] e_pc;
      fu_t         e_fu;
      logic        e_ex;
      logic        e_nv;
      logic        e_nm;
   } vec_t;

   function automatic vec_t mkv(input logic v, input fu_t fu, input logic [63:0] pc,
                                input logic ex, input logic ack_in, input logic flush,
                                input logic e_ack, input int e_cnt, input int e_mcnt,
                                input logic e_val, input logic [63:0] e_pc, input fu_t e_fu,
                                input logic e_ex, input logic e_nv, input logic e_nm);
      vec_t r;
      r.v = v; r.fu = fu; r.pc = pc; r.ex = ex; r.ack_in = ack_in; r.flush = flush;
      r.e_ack = e_ack; r.e_cnt = e_cnt; r.e_mcnt = e_mcnt; r.e_val = e_val;
      r.e_pc = e_pc; r.e_fu = e_fu; r.e_ex = e_ex; r.e_nv = e_nv; r.e_nm = e_nm;
      return r;
   endfunction

   // Deterministic entry contents derived from pc, fu and exception bit.
   function automatic scoreboard_entry_t mk(input logic [63:0] pc, input fu_t fu, input logic ex);
      scoreboard_entry_t e;
      e          = '0;
      e.pc       = pc;
      e.fu       = fu;
      e.result   = ~pc;
      e.trans_id = pc[4:2];
      e.rd       = pc[8:4];
      e.valid    = 1'b1;
      e.ex.valid = ex;
      e.ex.cause = ex ? 64'd2 : 64'd0;
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Control-flow flag is tied to pc bit 2 so it can be predicted per entry.
   task automatic drive(input logic v, input scoreboard_entry_t e, input logic ack, input logic fl);
      bus.decoded_entry_valid_i = v;
      bus.decoded_entry_i       = e;
      bus.is_ctrl_flow_i        = e.pc[2];
      bus.issue_instr_ack_i     = ack;
      bus.flush_i               = fl;
   endtask

   task automatic idle();
      drive(1'b0, mk(64'h0, NONE, 1'b0), 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t              vq[$];
      scoreboard_entry_t q[$];
      fu_t               pat[10];
      int                m;

      pat = '{STORE, ALU, LOAD, LOAD, ALU, STORE, ALU, ALU, LOAD, STORE};

      // v  fu     pc     ex ack fl | ack cnt m val pc     fu     ex nv nm
      vq.push_back(mkv(1, ALU,   'h80, 0, 0, 0,  1, 0, 0, 0, 'h00, NONE,  0, 0, 0));
      vq.push_back(mkv(1, LOAD,  'h84, 0, 0, 0,  1, 1, 0, 1, 'h80, ALU,   0, 0, 0));
      vq.push_back(mkv(1, STORE, 'h88, 0, 0, 0,  1, 2, 1, 1, 'h80, ALU,   0, 1, 1));
      vq.push_back(mkv(0, NONE,  'h00, 0, 0, 0,  0, 3, 2, 1, 'h80, ALU,   0, 1, 1));
      vq.push_back(mkv(1, ALU,   'h8C, 0, 0, 0,  1, 3, 2, 1, 'h80, ALU,   0, 1, 1));
      vq.push_back(mkv(1, ALU,   'h90, 0, 1, 0,  0, 4, 2, 1, 'h80, ALU,   0, 1, 1));
      vq.push_back(mkv(1, ALU,   'h90, 0, 0, 0,  1, 3, 2, 1, 'h84, LOAD,  0, 1, 1));
      vq.push_back(mkv(0, NONE,  'h00, 0, 0, 0,  0, 4, 2, 1, 'h84, LOAD,  0, 1, 1));
      vq.push_back(mkv(0, NONE,  'h00, 0, 1, 0,  0, 4, 2, 1, 'h84, LOAD,  0, 1, 1));
      vq.push_back(mkv(1, STORE, 'h94, 1, 1, 0,  1, 3, 1, 1, 'h88, STORE, 0, 1, 0));
      vq.push_back(mkv(1, LOAD,  'h98, 0, 1, 0,  1, 3, 1, 1, 'h8C, ALU,   0, 1, 0));
      vq.push_back(mkv(1, ALU,   'h9C, 0, 1, 0,  1, 3, 2, 1, 'h90, ALU,   0, 1, 1));
      vq.push_back(mkv(0, NONE,  'h00, 0, 1, 0,  0, 3, 2, 1, 'h94, STORE, 1, 1, 1));
      vq.push_back(mkv(0, NONE,  'h00, 0, 1, 0,  0, 2, 1, 1, 'h98, LOAD,  0, 1, 0));
      vq.push_back(mkv(0, NONE,  'h00, 0, 1, 0,  0, 1, 0, 1, 'h9C, ALU,   0, 0, 0));
      vq.push_back(mkv(0, NONE,  'h00, 0, 0, 0,  0, 0, 0, 0, 'h00, NONE,  0, 0, 0));
      vq.push_back(mkv(1, ALU,   'hA0, 0, 1, 0,  1, 0, 0, 0, 'h00, NONE,  0, 0, 0));
      vq.push_back(mkv(0, NONE,  'h00, 0, 0, 0,  0, 1, 0, 1, 'hA0, ALU,   0, 0, 0));
      vq.push_back(mkv(0, NONE,  'h00, 0, 1, 0,  0, 1, 0, 1, 'hA0, ALU,   0, 0, 0));
      vq.push_back(mkv(0, NONE,  'h00, 0, 0, 0,  0, 0, 0, 0, 'h00, NONE,  0, 0, 0));

      // Reset: outputs empty and push refused while reset is high.
      rst_i = 1'b1;
      drive(1'b1, mk(64'h40, LOAD, 1'b0), 1'b1, 1'b0);
      #2;
      check("reset_ack",   64'(bus.decoded_entry_ack_o), 64'd0);
      check("reset_valid", 64'(bus.issue_entry_valid_o), 64'd0);
      check("reset_cnt",   64'(bus.count_o),             64'd0);
      check("reset_mcnt",  64'(bus.mem_count_o),         64'd0);
      check("reset_nv",    64'(bus.next_valid_o),        64'd0);
      check("reset_nm",    64'(bus.next_is_mem_o),       64'd0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      idle();

      // Table: inputs applied one time unit after the edge, outputs checked
      // one unit later; the following edge consumes the inputs.
      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk_i);
         #1;
         drive(vq[i].v, mk(vq[i].pc, vq[i].fu, vq[i].ex), vq[i].ack_in, vq[i].flush);
         #1;
         check($sformatf("row%0d_ack", i),  64'(bus.decoded_entry_ack_o), 64'(vq[i].e_ack));
         check($sformatf("row%0d_cnt", i),  64'(bus.count_o),             64'(vq[i].e_cnt));
         check($sformatf("row%0d_mcnt", i), 64'(bus.mem_count_o),         64'(vq[i].e_mcnt));
         check($sformatf("row%0d_val", i),  64'(bus.issue_entry_valid_o), 64'(vq[i].e_val));
         check($sformatf("row%0d_nv", i),   64'(bus.next_valid_o),        64'(vq[i].e_nv));
         check($sformatf("row%0d_nm", i),   64'(bus.next_is_mem_o),       64'(vq[i].e_nm));
         if (vq[i].e_val) begin
            check($sformatf("row%0d_pc", i),   bus.issue_entry_o.pc,           vq[i].e_pc);
            check($sformatf("row%0d_fu", i),   64'(bus.issue_entry_o.fu),      64'(vq[i].e_fu));
            check($sformatf("row%0d_ex", i),   64'(bus.issue_entry_o.ex.valid), 64'(vq[i].e_ex));
            check($sformatf("row%0d_ctrl", i), 64'(bus.is_ctrl_flow_o),        64'(vq[i].e_pc[2]));
            check($sformatf("row%0d_entry", i),
                  64'(bus.issue_entry_o == mk(vq[i].e_pc, vq[i].e_fu, vq[i].e_ex)), 64'd1);
         end
      end

      // Steady state: two held entries, push and pop every cycle.
      @(posedge clk_i); #1 drive(1'b1, mk(64'hB0, LOAD, 1'b0), 1'b0, 1'b0);
      q.push_back(mk(64'hB0, LOAD, 1'b0));
      @(posedge clk_i); #1 drive(1'b1, mk(64'hB4, ALU, 1'b0), 1'b0, 1'b0);
      q.push_back(mk(64'hB4, ALU, 1'b0));
      for (int k = 0; k < 10; k++) begin
         @(posedge clk_i);
         #1;
         drive(1'b1, mk(64'hC0 + 64'(4 * k), pat[k], 1'b0), 1'b1, 1'b0);
         #1;
         m = 0;
         foreach (q[j]) if (q[j].fu == LOAD || q[j].fu == STORE) m++;
         check($sformatf("steady%0d_cnt", k),  64'(bus.count_o),     64'd2);
         check($sformatf("steady%0d_mcnt", k), 64'(bus.mem_count_o), 64'(m));
         check($sformatf("steady%0d_pc", k),   bus.issue_entry_o.pc, q[0].pc);
         void'(q.pop_front());
         q.push_back(mk(64'hC0 + 64'(4 * k), pat[k], 1'b0));
      end
      @(posedge clk_i); #1 drive(1'b0, mk(64'h0, NONE, 1'b0), 1'b1, 1'b0);
      @(posedge clk_i); #1 drive(1'b0, mk(64'h0, NONE, 1'b0), 1'b1, 1'b0);
      @(posedge clk_i); #1 idle();
      #1 check("drain_cnt", 64'(bus.count_o), 64'd0);

      // Flush with three held entries while pushing and popping.
      @(posedge clk_i); #1 drive(1'b1, mk(64'hD0, LOAD,  1'b0), 1'b0, 1'b0);
      @(posedge clk_i); #1 drive(1'b1, mk(64'hD4, STORE, 1'b0), 1'b0, 1'b0);
      @(posedge clk_i); #1 drive(1'b1, mk(64'hD8, ALU,   1'b0), 1'b0, 1'b0);
      @(posedge clk_i); #1 drive(1'b1, mk(64'hDC, LOAD,  1'b0), 1'b1, 1'b1);
      #1;
      check("flush_ack",     64'(bus.decoded_entry_ack_o), 64'd0);
      check("flush_pre_cnt", 64'(bus.count_o),             64'd3);
      check("flush_pre_mc",  64'(bus.mem_count_o),         64'd2);
      @(posedge clk_i); #1 drive(1'b1, mk(64'hE0, ALU, 1'b0), 1'b0, 1'b0);
      #1;
      check("flush_cnt",   64'(bus.count_o),             64'd0);
      check("flush_mcnt",  64'(bus.mem_count_o),         64'd0);
      check("flush_valid", 64'(bus.issue_entry_valid_o), 64'd0);
      check("flush_nv",    64'(bus.next_valid_o),        64'd0);
      check("post_flush_ack", 64'(bus.decoded_entry_ack_o), 64'd1);
      @(posedge clk_i); #1 drive(1'b1, mk(64'hF0, LOAD, 1'b0), 1'b0, 1'b0);
      #1;
      check("post_flush_cnt", 64'(bus.count_o),     64'd1);
      check("post_flush_pc",  bus.issue_entry_o.pc, 64'hE0);

      // Asynchronous reset mid-cycle with two entries held.
      @(posedge clk_i); #1 idle();
      #1;
      check("pre_rst_cnt",   64'(bus.count_o),             64'd2);
      check("pre_rst_mcnt",  64'(bus.mem_count_o),         64'd1);
      check("pre_rst_valid", 64'(bus.issue_entry_valid_o), 64'd1);
      @(negedge clk_i);
      drive(1'b1, mk(64'h100, ALU, 1'b0), 1'b0, 1'b0);
      rst_i = 1'b1;
      #1;
      check("async_rst_valid", 64'(bus.issue_entry_valid_o), 64'd0);
      check("async_rst_cnt",   64'(bus.count_o),             64'd0);
      check("async_rst_mcnt",  64'(bus.mem_count_o),         64'd0);
      check("async_rst_ack",   64'(bus.decoded_entry_ack_o), 64'd0);
      @(posedge clk_i); #1 rst_i = 1'b0;
      idle();
      #1;
      check("after_rst_cnt",   64'(bus.count_o),             64'd0);
      check("after_rst_valid", 64'(bus.issue_entry_valid_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/issue_entry_fifo.md
Name: issue_entry_fifo

Overview:
- Decoupling buffer between the decode/ID stage and the issue-side instruction reorder stage.
- Holds up to DEPTH decoded scoreboard entries together with their control-flow flags.
- Presents the oldest entry with the same valid/ack handshake the reorder stage consumes.
- Also exposes a one-entry lookahead and a memory-op occupancy count, so the reorder stage can decide whether delaying a LOAD/STORE is worthwhile.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived; not overridable)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
flush_i  input  1  synchronous flush of all held entries
decoded_entry_i  input  ariane_pkg::scoreboard_entry_t  decoded instruction from ID
decoded_entry_valid_i  input  1  decoded_entry_i is valid
is_ctrl_flow_i  input  1  entry is a control-flow instruction
decoded_entry_ack_o  output  1  entry accepted this cycle
issue_entry_o  output  ariane_pkg::scoreboard_entry_t  oldest held entry
issue_entry_valid_o  output  1  issue_entry_o is valid
is_ctrl_flow_o  output  1  control-flow flag of the oldest entry
issue_instr_ack_i  input  1  downstream consumed the oldest entry
next_valid_o  output  1  a second-oldest entry exists
next_is_mem_o  output  1  second-oldest entry has fu LOAD or STORE
count_o  output  PTR_W+1  number of held entries, 0..DEPTH
mem_count_o  output  PTR_W+1  held entries with fu LOAD or STORE

Behaviour:
- Storage:
  - Circular buffer of {sbe, is_ctrl_flow}, read pointer rd_q, write pointer wr_q (PTR_W bits), counter cnt_q (PTR_W+1 bits), mem counter mcnt_q (PTR_W+1 bits).
  - Pointers wrap naturally modulo DEPTH.
- Reset (rst_i high, asynchronous):
  - rd_q = wr_q = cnt_q = mcnt_q = 0.
  - Hence issue_entry_valid_o = 0, next_valid_o = 0, next_is_mem_o = 0, count_o = 0, mem_count_o = 0.
  - decoded_entry_ack_o = 0 while rst_i is high.
  - Storage array contents need not be reset; issue_entry_o is don't-care while valid is 0.
- Push:
  - decoded_entry_ack_o = decoded_entry_valid_i & (cnt_q != DEPTH) & !flush_i, combinationally.
  - When ack is high, the entry is written at wr_q and wr_q increments at the clock edge.
  - No bypass: an entry pushed in cycle t is first visible on issue_entry_o in cycle t+1 (latency 1).
- Pop:
  - issue_entry_valid_o = (cnt_q != 0).
  - issue_entry_o / is_ctrl_flow_o = storage[rd_q].
  - pop = issue_instr_ack_i & issue_entry_valid_o & !flush_i; rd_q increments on pop.
  - issue_instr_ack_i while empty is ignored.
- Counter update:
  - cnt_n = cnt_q + push - pop.
  - Simultaneous push and pop leave the count unchanged.
- Full:
  - When cnt_q == DEPTH, ack_o = 0 even if a pop occurs in the same cycle (no combinational pop-to-push path).
  - The entry is accepted the following cycle.
- Empty:
  - When cnt_q == 0, push and pop cannot coincide on the same entry; the push lands and valid rises the next cycle.
- Lookahead:
  - next_valid_o = (cnt_q >= 2).
  - next_is_mem_o = next_valid_o & fu of storage[rd_q+1] ∈ {LOAD, STORE}.
- Memory count:
  - mcnt_n = mcnt_q + (push & incoming fu ∈ {LOAD, STORE}) − (pop & head fu ∈ {LOAD, STORE}).
  - Invariant: mcnt_q <= cnt_q.
- Flush (flush_i high at an edge):
  - rd_q, wr_q, cnt_q, mcnt_q go to 0 the next cycle.
  - Push ack and pop are both suppressed in the flush cycle.
  - Flush has priority over push and pop.
- Exceptions: entries with sbe.ex.valid pass through unmodified and count by their fu like any other entry.
- Outputs are purely a function of registered state, except decoded_entry_ack_o, which also depends on decoded_entry_valid_i and flush_i.

Test Plan:
- Reset, then push 3 entries (fu ALU, LOAD, STORE) with issue_instr_ack_i=0.
  - Response: count_o=3, mem_count_o=2, issue_entry_o.fu=ALU, next_valid_o=1, next_is_mem_o=1.
- Fill to DEPTH=4, hold decoded_entry_valid_i=1 and pulse issue_instr_ack_i for one cycle.
  - Response: ack_o=0 in the pop cycle, ack_o=1 the next cycle, count_o returns to 4.
  - Order of popped entries matches push order across pointer wrap (8 pushes, 8 pops, pc values 0x80..0x9C checked).
- Empty FIFO, push with issue_instr_ack_i=1 in the same cycle.
  - Response: issue_entry_valid_o=0 in that cycle, =1 the next cycle, count_o=1; the spurious ack is ignored.
- Steady state with simultaneous push and pop every cycle for 10 cycles.
  - Response: count_o constant at 2; mem_count_o tracks LOAD/STORE mix exactly.
- flush_i with count_o=3, decoded_entry_valid_i=1, issue_instr_ack_i=1.
  - Response: ack_o=0 that cycle; next cycle count_o=0, mem_count_o=0, issue_entry_valid_o=0.
- Assert rst_i asynchronously mid-cycle with 2 entries held.
  - Response: issue_entry_valid_o and count_o drop to 0 immediately, before the next clock edge.
